ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Multi-cycle integer multiply/divide unit that sits beside the single-cycle EX ALU.
- Owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU iteratively, plus MTHI/MTLO writes.
- Exposes HI/LO to the EX result mux, and stalls the pipeline when an MFHI/MFLO arrives while an operation is in flight.

Parameters:
- DATA_WIDTH, 32: operand and HI/LO width. Must be even and >=8.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1: iteration counter width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request to issue op with operands A, B this cycle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
- A  in  DATA_WIDTH  forwarded rs value (multiplicand/dividend/MT source)
- B  in  DATA_WIDTH  forwarded rt value (multiplier/divisor)
- flush  in  1  kill in-flight op (branch mispredict/exception)
- mf_req  in  1  MFHI/MFLO present in EX this cycle
- ready  out  1  unit idle, start will be accepted
- busy  out  1  iterative op in flight
- done  out  1  one-cycle pulse; HI/LO hold new result this cycle
- stall  out  1  mf_req & busy
- hi  out  DATA_WIDTH  HI register
- lo  out  DATA_WIDTH  LO register

Behaviour:
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0, ready=1, internal counter/accumulators 0.
- States: IDLE, MUL, DIV, FIXUP.
- ready = (state==IDLE). start with !ready is ignored; the pipeline holds the instruction.
- IDLE, accepting start:
  - op 0-1: latch |A|, |B| (signed ops) or raw operands, plus the sign-difference flag; counter=DATA_WIDTH; go to MUL.
  - op 2-3: latch operands, dividend sign and quotient sign; go to DIV.
  - op 4: hi<=A at next edge, no busy, no done.
  - op 5: lo<=A at next edge, no busy, no done.
  - op 6-7: no effect.
- MUL: radix-2 shift-add, one multiplier bit per cycle; counter decrements; at 0 go to FIXUP.
- DIV: radix-2 restoring divide, one quotient bit per cycle, 2*DATA_WIDTH-bit partial remainder; at counter 0 go to FIXUP.
- FIXUP: apply signs.
  - Product: negated if signs differ.
  - Quotient: negated if signs differ.
  - Remainder: takes the dividend's sign.
  - Write hi/lo (MUL: hi=product upper half, lo=lower half; DIV: hi=remainder, lo=quotient); go to IDLE.
- done=1 in the first IDLE cycle after FIXUP.
- Latency: start sampled at edge k; busy=1 for cycles k+1..k+DATA_WIDTH+1; done=1 and new hi/lo visible in cycle k+DATA_WIDTH+2. A new start is accepted in the done cycle.
- Divide by zero (B==0, sampled at start): runs full latency; result lo=all ones, hi=A, for both DIV and DIVU.
- Signed overflow (A=most negative, B=-1): lo=most negative, hi=0. This is the natural magnitude-algorithm result; no special case needed beyond correct width.
- Flush: in any busy state, next state is IDLE; hi/lo unchanged; no done pulse.
  - flush with start in IDLE: start dropped, including MTHI/MTLO.
  - flush in the FIXUP cycle: write suppressed.
- stall is combinational: mf_req & busy. It is 0 in the done cycle, so an MF in that cycle reads the new value.
- Reset mid-operation: immediate return to the reset state.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle combinational DATA_WIDTH x DATA_WIDTH multiplier, registered into the accumulator. MUL state is skipped (IDLE->FIXUP), so busy lasts 1 cycle and done appears in cycle k+2. Division is unchanged.
- Undefined: iterative MUL as above.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done at k+34, hi=0xFFFFFFFE lo=0x00000001 (k+2 with MULDIV_FAST_MUL_EN).
- MULT A=0xFFFFFFFD(-3) B=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; then DIV A=0xFFFFFFF9(-7) B=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIVU A=0x12345678 B=0 -> lo=0xFFFFFFFF hi=0x12345678. DIV A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000 hi=0.
- Preload hi=0xAA via MTHI; start DIVU 100/7, flush at k+10 -> busy=0 from k+11, no done, hi=0xAA unchanged. A following start is accepted and DIVU 100/7 gives lo=14 hi=2.
- During busy: mf_req=1 -> stall=1 each busy cycle, 0 in the done cycle. MTHI start while busy -> ignored, hi unchanged.
- Assert reset at k+5 of a MULT -> hi=lo=0, busy=0, ready=1 immediately, no done.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The pipeline side drives the request; the unit returns status and HI/LO.
`timescale 1ns/1ps
interface ex_muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  flush;
  logic                  mf_req;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  stall;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, op, A, B, flush, mf_req,
    input  ready, busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, A, B, flush, mf_req,
    output ready, busy, done, stall, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO and MF stall.
// Build option MULDIV_FAST_MUL_EN: single-cycle multiplier, MUL state skipped.
`timescale 1ns/1ps
module ex_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic       clock,
  input  logic       reset,
  ex_muldiv_if.slave bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         opb_q, opb_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 is_div_q, is_div_d;
  logic                 done_q, done_d;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_signed);
    return (is_signed && v[W-1]) ? -v : v;
  endfunction

  function automatic logic [W-1:0] apply_sign(input logic [W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] apply_sign_wide(input logic [2*W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic         op_signed;
  logic         sign_diff;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;

  assign op_signed = ~bus.op[0];
  assign sign_diff = bus.A[W-1] ^ bus.B[W-1];
  assign a_mag     = magnitude(bus.A, op_signed);
  assign b_mag     = magnitude(bus.B, op_signed);

  // Shift-add step: acc holds {partial product high, unconsumed multiplier bits}.
`ifndef MULDIV_FAST_MUL_EN
  logic [W:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, opb_q & {W{acc_q[0]}}};
`else
  logic [2*W-1:0] fast_prod;
  assign fast_prod = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
`endif

  // Restoring step: acc holds {remainder, dividend bits / quotient bits}.
  logic         div_ge;
  logic [W-1:0] div_sub;
  logic [W-1:0] div_rem;
  assign div_ge  = acc_q[2*W-1:W-1] >= {1'b0, opb_q};
  assign div_sub = acc_q[2*W-2:W-1] - opb_q;
  assign div_rem = div_ge ? div_sub : acc_q[2*W-2:W-1];

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix;
  logic [W-1:0]   rem_fix;
  assign prod_fix = apply_sign_wide(acc_q, neg_q);
  assign quot_fix = apply_sign(acc_q[W-1:0], neg_q);
  assign rem_fix  = apply_sign(acc_q[2*W-1:W], rneg_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.op)
            3'd0, 3'd1: begin
              neg_d    = op_signed & sign_diff;
              rneg_d   = 1'b0;
              is_div_d = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
              acc_d    = fast_prod;
              state_d  = FIXUP;
`else
              opb_d    = a_mag;
              acc_d    = {{W{1'b0}}, b_mag};
              cnt_d    = CNT_WIDTH'(W);
              state_d  = MUL;
`endif
            end
            3'd2, 3'd3: begin
              // A zero divisor must leave the all-ones quotient un-negated.
              neg_d    = op_signed & sign_diff & (bus.B != '0);
              rneg_d   = op_signed & bus.A[W-1];
              is_div_d = 1'b1;
              opb_d    = b_mag;
              acc_d    = {{W{1'b0}}, a_mag};
              cnt_d    = CNT_WIDTH'(W);
              state_d  = DIV;
            end
            3'd4:    hi_d = bus.A;
            3'd5:    lo_d = bus.A;
            default: ;
          endcase
        end
      end

      MUL: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
`ifndef MULDIV_FAST_MUL_EN
          acc_d = {mul_sum, acc_q[W-1:1]};
`endif
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_WIDTH'(1)) state_d = FIXUP;
        end
      end

      DIV: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = {div_rem, acc_q[W-2:0], div_ge};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_WIDTH'(1)) state_d = FIXUP;
        end
      end

      FIXUP: begin
        state_d = IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*W-1:W];
            lo_d = prod_fix[W-1:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.stall = bus.mf_req & (state_q != IDLE);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed bench for ex_muldiv against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ex_muldiv;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ex_muldiv_if #(.DATA_WIDTH(W)) bus();
  ex_muldiv #(.DATA_WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    longint     sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0; l = '0;
    case (o)
      3'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (b == '0) begin h = a; l = '1; end
        else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      default: begin
        if (b == '0) begin h = a; l = '1; end
        else begin h = a % b; l = a / b; end
      end
    endcase
  endfunction

  // Caller is positioned at a negedge; start is sampled at the following posedge (edge k).
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.op = 3'd7;
  endtask

  // Runs one iterative op and returns at the negedge of the done cycle (or timeout).
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic mf, output int lat, output int bad,
                       output logic [W-1:0] h, output logic [W-1:0] l);
    int exp_lat;
    exp_lat = (o < 3'd2) ? MUL_LAT : DIV_LAT;
    lat = -1; bad = 0; h = 'x; l = 'x;
    bus.mf_req = mf;
    issue(o, a, b);
    for (int n = 1; n <= exp_lat + 10; n++) begin
      @(negedge clock);
      if (n <= exp_lat) begin
        if (bus.busy !== (n < exp_lat)) bad++;
        if (bus.stall !== (mf && (n < exp_lat))) bad++;
        if (bus.ready !== (n == exp_lat)) bad++;
      end else begin
        bad++;
      end
      if (bus.done === 1'b1) begin
        lat = n; h = bus.hi; l = bus.lo;
        break;
      end
    end
    bus.mf_req = 1'b0;
  endtask

  task automatic test_reset;
    bus.mf_req = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.hi !== '0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== '0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    bus.mf_req = 1'b0;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_mul_directed;
    int lat, bad; logic [W-1:0] h, l;
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bad, h, l);
    checks++; if (lat !== MUL_LAT) begin failures++; $display("FAIL multu_latency got=%0d exp=%0d", lat, MUL_LAT); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL multu_handshake bad_cycles=%0d exp=0", bad); end
    checks++; if (h !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", h); end
    checks++; if (l !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", l); end
    do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, lat, bad, h, l);
    checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFF1) begin
      failures++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_fffffff1", h, l); end
  endtask

  task automatic test_div_directed;
    int lat, bad; logic [W-1:0] h, l;
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bad, h, l);
    checks++; if (lat !== DIV_LAT) begin failures++; $display("FAIL div_latency got=%0d exp=%0d", lat, DIV_LAT); end
    checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
      failures++; $display("FAIL div_neg got=%h_%h exp=ffffffff_fffffffd", h, l); end
    do_op(3'd3, 32'h1234_5678, 32'd0, 1'b0, lat, bad, h, l);
    checks++; if (h !== 32'h1234_5678 || l !== 32'hFFFF_FFFF || lat !== DIV_LAT) begin
      failures++; $display("FAIL divu_by_zero got=%h_%h lat=%0d exp=12345678_ffffffff lat=%0d", h, l, lat, DIV_LAT); end
    do_op(3'd2, 32'hF000_0000, 32'd0, 1'b0, lat, bad, h, l);
    checks++; if (h !== 32'hF000_0000 || l !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL div_by_zero_neg got=%h_%h exp=f0000000_ffffffff", h, l); end
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bad, h, l);
    checks++; if (h !== 32'h0 || l !== 32'h8000_0000) begin
      failures++; $display("FAIL div_overflow got=%h_%h exp=00000000_80000000", h, l); end
  endtask

  task automatic test_random;
    int lat, bad, exp_lat; logic [W-1:0] h, l, eh, el, a, b; logic [2:0] o;
    logic [W-1:0] corner [5];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 3))
        0: b = corner[$urandom_range(0, 4)];
        1: b = W'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      model(o, a, b, eh, el);
      exp_lat = (o < 3'd2) ? MUL_LAT : DIV_LAT;
      do_op(o, a, b, i[0], lat, bad, h, l);
      checks++; if (h !== eh || l !== el || lat !== exp_lat || bad !== 0) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h_%h lat=%0d bad=%0d exp=%h_%h lat=%0d",
                 i, o, a, b, h, l, lat, bad, eh, el, exp_lat);
      end
    end
  endtask

  task automatic test_stall_and_busy_start;
    int lat, bad, n; logic [W-1:0] h, l, h0; logic seen;
    do_op(3'd3, 32'd1000, 32'd33, 1'b1, lat, bad, h, l);
    checks++; if (bad !== 0 || lat !== DIV_LAT) begin
      failures++; $display("FAIL stall_window bad_cycles=%0d lat=%0d exp=0 lat=%0d", bad, lat, DIV_LAT); end
    h0 = bus.hi;
    issue(3'd3, 32'd100, 32'd7);
    @(negedge clock);
    bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'h5555_5555;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.op = 3'd7;
    checks++; if (bus.hi !== h0 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL mthi_while_busy hi=%h busy=%b exp hi=%h busy=1", bus.hi, bus.busy, h0); end
    seen = 1'b0; n = 1;
    while (!seen && n < DIV_LAT + 10) begin
      n++; @(negedge clock);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++; if (n !== DIV_LAT || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      failures++; $display("FAIL busy_start_ignored done_at=%0d got=%h_%h exp=%0d 00000002_0000000e", n, bus.hi, bus.lo, DIV_LAT); end
  endtask

  task automatic test_flush;
    int lat, bad, dones; logic [W-1:0] h, l, h0, l0;
    issue(3'd4, 32'h0000_00AA, 32'd0);
    checks++; if (bus.hi !== 32'hAA || bus.busy !== 1'b0) begin
      failures++; $display("FAIL mthi got hi=%h busy=%b exp=000000aa busy=0", bus.hi, bus.busy); end
    @(negedge clock);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mthi_done got=%b exp=0", bus.done); end
    issue(3'd3, 32'd100, 32'd7);
    repeat (8) @(posedge clock);
    #1 bus.flush = 1'b1;
    @(posedge clock); #1 bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
      failures++; $display("FAIL flush_idle busy=%b ready=%b exp busy=0 ready=1", bus.busy, bus.ready); end
    dones = 0;
    repeat (DIV_LAT + 4) begin @(negedge clock); if (bus.done === 1'b1) dones++; end
    checks++; if (dones !== 0 || bus.hi !== 32'hAA) begin
      failures++; $display("FAIL flush_no_done dones=%0d hi=%h exp dones=0 hi=000000aa", dones, bus.hi); end
    do_op(3'd3, 32'd100, 32'd7, 1'b0, lat, bad, h, l);
    checks++; if (h !== 32'd2 || l !== 32'd14 || lat !== DIV_LAT) begin
      failures++; $display("FAIL after_flush got=%h_%h lat=%0d exp=00000002_0000000e lat=%0d", h, l, lat, DIV_LAT); end
    // Flush landing on the FIXUP cycle.
    h0 = bus.hi; l0 = bus.lo;
    issue(3'd3, 32'd999, 32'd10);
    repeat (W) @(posedge clock);
    #1 bus.flush = 1'b1;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL fixup_busy got=%b exp=1", bus.busy); end
    @(posedge clock); #1 bus.flush = 1'b0;
    dones = 0;
    repeat (4) begin @(negedge clock); if (bus.done === 1'b1) dones++; end
    checks++; if (dones !== 0 || bus.hi !== h0 || bus.lo !== l0) begin
      failures++; $display("FAIL flush_fixup dones=%0d got=%h_%h exp dones=0 %h_%h", dones, bus.hi, bus.lo, h0, l0); end
    // Flush together with an MTLO start in IDLE.
    bus.flush = 1'b1;
    issue(3'd5, 32'h1234_0000, 32'd0);
    bus.flush = 1'b0;
    checks++; if (bus.lo !== l0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL flush_mtlo lo=%h busy=%b exp lo=%h busy=0", bus.lo, bus.busy, l0); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    int dones;
    issue(3'd0, 32'd7, 32'd9);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_mid hi=%h lo=%h busy=%b ready=%b done=%b exp 0 0 0 1 0",
                           bus.hi, bus.lo, bus.busy, bus.ready, bus.done); end
    @(negedge clock); reset = 1'b0;
    dones = 0;
    repeat (MUL_LAT + 4) begin @(negedge clock); if (bus.done === 1'b1 || bus.busy === 1'b1) dones++; end
    checks++; if (dones !== 0) begin failures++; $display("FAIL reset_mid_quiet active_cycles=%0d exp=0", dones); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd7; bus.A = '0; bus.B = '0;
    bus.flush = 1'b0; bus.mf_req = 1'b0;
    test_reset;
    test_mul_directed;
    test_div_directed;
    test_random;
    test_stall_and_busy_start;
    test_flush;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
